// File: rtl/atm_channel_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : atm_channel_sequencer_if
//  Description : Control/data bundle between a frame source, the ADC and
//                the ATM channel sequencer. The slave modport is the
//                sequencer side; the master modport is the environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface atm_channel_sequencer_if;
    logic        ENSAMP_sync;
    logic        FRAME_TRIG;
    logic [7:0]  CHEN;
    logic [15:0] ADC_RESULT;
    logic        ADC_DONE;
    logic        ADC_START;
    logic [7:0]  ATMCHSEL;
    logic [15:0] RESULT;
    logic        DONE;
    logic        LASTWORD;
    logic        BUSY;
    logic        TRIG_OVERRUN;
    logic        ADC_TIMEOUT;

    modport slave (
        input  ENSAMP_sync, FRAME_TRIG, CHEN, ADC_RESULT, ADC_DONE,
        output ADC_START, ATMCHSEL, RESULT, DONE, LASTWORD, BUSY,
               TRIG_OVERRUN, ADC_TIMEOUT
    );

    modport master (
        output ENSAMP_sync, FRAME_TRIG, CHEN, ADC_RESULT, ADC_DONE,
        input  ADC_START, ATMCHSEL, RESULT, DONE, LASTWORD, BUSY,
               TRIG_OVERRUN, ADC_TIMEOUT
    );
endinterface
`default_nettype wire

// File: rtl/atm_channel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : atm_channel_sequencer
//  Description : Walks the enabled channels of a frame from lowest to
//                highest, requesting one ADC conversion per channel and
//                emitting a write strobe with the captured result.
//                Optional macro SEQ_TIMEOUT_EN adds a conversion-wait
//                timeout that emits 16'hFFFF and toggles ADC_TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module atm_channel_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic              SAMPLE_CLK,
    input  wire logic              RST_sync,
    atm_channel_sequencer_if.slave sif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_CONV  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    // Out-of-range limits are rejected at elaboration time.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    // One-hot of the lowest set bit of a vector (zero stays zero).
    function automatic logic [7:0] f_lowest(input logic [7:0] v);
        f_lowest = v & (~v + 8'd1);
    endfunction

    state_t      r_state, w_state_nx;
    logic [7:0]  r_mask, w_mask_nx;
    logic [7:0]  r_chsel, w_chsel_nx;
    logic        r_adc_start, w_adc_start_nx;
    logic [15:0] r_result, w_result_nx;
    logic        r_done, w_done_nx;
    logic        r_last, w_last_nx;
    logic        r_busy, w_busy_nx;
    logic        r_trig_ovr, w_trig_ovr_nx;
    logic [7:0]  w_higher;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  r_to_cnt, w_to_cnt_nx;
    logic        r_adc_to, w_adc_to_nx;
`endif

    // Enabled channels above the one currently selected; zero means last word.
    assign w_higher = r_mask & ~(r_chsel | (r_chsel - 8'd1));

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nx     = r_state;
        w_mask_nx      = r_mask;
        w_chsel_nx     = r_chsel;
        w_adc_start_nx = 1'b0;
        w_result_nx    = r_result;
        w_done_nx      = 1'b0;
        w_last_nx      = 1'b0;
        // Any trigger seen while a frame is in flight is dropped and flagged.
        w_trig_ovr_nx  = r_trig_ovr ^ (sif.FRAME_TRIG && (r_state != ST_IDLE));
`ifdef SEQ_TIMEOUT_EN
        w_to_cnt_nx    = r_to_cnt;
        w_adc_to_nx    = r_adc_to;
`endif
        if (!sif.ENSAMP_sync) begin
            // Abort: no partial-frame strobe, datapath cleared, toggles kept.
            w_state_nx  = ST_IDLE;
            w_mask_nx   = 8'd0;
            w_chsel_nx  = 8'd0;
            w_result_nx = 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_chsel_nx = 8'd0;
                    if (sif.FRAME_TRIG && (sif.CHEN != 8'd0)) begin
                        w_mask_nx      = sif.CHEN;
                        w_chsel_nx     = f_lowest(sif.CHEN);
                        w_adc_start_nx = 1'b1;
                        w_state_nx     = ST_START;
                    end
                end
                ST_START: begin
                    w_state_nx = ST_CONV;
`ifdef SEQ_TIMEOUT_EN
                    w_to_cnt_nx = 8'd0;
`endif
                end
                ST_CONV: begin
                    // A real result on the limit cycle takes precedence.
                    if (sif.ADC_DONE) begin
                        w_result_nx = sif.ADC_RESULT;
                        w_done_nx   = 1'b1;
                        w_last_nx   = (w_higher == 8'd0);
                        w_state_nx  = ST_EMIT;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (r_to_cnt == c_TO_LAST) begin
                        w_result_nx = 16'hFFFF;
                        w_done_nx   = 1'b1;
                        w_last_nx   = (w_higher == 8'd0);
                        w_adc_to_nx = ~r_adc_to;
                        w_state_nx  = ST_EMIT;
                    end else begin
                        w_to_cnt_nx = r_to_cnt + 8'd1;
                    end
`endif
                end
                ST_EMIT: begin
                    if (w_higher == 8'd0) begin
                        w_chsel_nx = 8'd0;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_chsel_nx     = f_lowest(w_higher);
                        w_adc_start_nx = 1'b1;
                        w_state_nx     = ST_START;
                    end
                end
                default: begin
                    w_chsel_nx = 8'd0;
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge SAMPLE_CLK or posedge RST_sync) begin
        if (RST_sync) begin
            r_state     <= ST_IDLE;
            r_mask      <= 8'd0;
            r_chsel     <= 8'd0;
            r_adc_start <= 1'b0;
            r_result    <= 16'd0;
            r_done      <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_trig_ovr  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_mask      <= w_mask_nx;
            r_chsel     <= w_chsel_nx;
            r_adc_start <= w_adc_start_nx;
            r_result    <= w_result_nx;
            r_done      <= w_done_nx;
            r_last      <= w_last_nx;
            r_busy      <= w_busy_nx;
            r_trig_ovr  <= w_trig_ovr_nx;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Conversion-wait counter and timeout event toggle.
    always_ff @(posedge SAMPLE_CLK or posedge RST_sync) begin
        if (RST_sync) begin
            r_to_cnt <= 8'd0;
            r_adc_to <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_nx;
            r_adc_to <= w_adc_to_nx;
        end
    end

    assign sif.ADC_TIMEOUT = r_adc_to;
`else
    assign sif.ADC_TIMEOUT = 1'b0;
`endif

    assign sif.ADC_START    = r_adc_start;
    assign sif.ATMCHSEL     = r_chsel;
    assign sif.RESULT       = r_result;
    assign sif.DONE         = r_done;
    assign sif.LASTWORD     = r_last;
    assign sif.BUSY         = r_busy;
    assign sif.TRIG_OVERRUN = r_trig_ovr;

endmodule
`default_nettype wire

// File: doc/atm_channel_sequencer.md
ATM_CHANNEL_SEQUENCER -- requirements
Module: atm_channel_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the conversion-wait limit in SAMPLE_CLK cycles (range 1-255, 8-bit counter).
REQ-002 SAMPLE_CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST_sync  in  1  reset, asynchronous assert, active-high.
REQ-004 ENSAMP_sync  in  1  sampling enable; low SHALL abort any frame.
REQ-005 FRAME_TRIG  in  1  single-cycle pulse that starts a frame.
REQ-006 CHEN  in  8  channel enable mask; bit n enables channel n.
REQ-007 ADC_RESULT  in  16  conversion result; valid only in the ADC_DONE cycle.
REQ-008 ADC_DONE  in  1  single-cycle conversion-complete pulse.
REQ-009 ADC_START  out  1  single-cycle conversion request.
REQ-010 ATMCHSEL  out  8  one-hot active channel; all-zero when idle.
REQ-011 RESULT  out  16  captured conversion word for the downstream frame FIFO.
REQ-012 DONE  out  1  single-cycle write strobe qualifying RESULT/ATMCHSEL/LASTWORD.
REQ-013 LASTWORD  out  1  high with DONE on the highest enabled channel of the frame.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 TRIG_OVERRUN  out  1  event toggle; inverts once per rejected trigger.
REQ-016 ADC_TIMEOUT  out  1  event toggle; inverts once per conversion timeout.

Function
REQ-017 FSM states: IDLE, START, CONV, EMIT; all outputs SHALL be registered.
REQ-018 IDLE: FRAME_TRIG & ENSAMP_sync & (CHEN != 0) -> latch CHEN to internal mask, select lowest set bit, go START.
REQ-019 IDLE: FRAME_TRIG with CHEN == 0 SHALL be ignored; no DONE, no overrun toggle.
REQ-020 START: ADC_START=1 for exactly this cycle, ATMCHSEL=one-hot of selected channel -> CONV.
REQ-021 CONV: ADC_DONE captures ADC_RESULT into RESULT -> EMIT; ADC_DONE outside CONV SHALL be ignored.
REQ-022 EMIT: DONE=1 for one cycle; LASTWORD=1 iff no higher bit is set in the latched mask.
REQ-023 EMIT: LASTWORD=1 -> IDLE; else select next higher set bit -> START.
REQ-024 Per-channel latency: DONE SHALL assert exactly 1 cycle after the ADC_DONE cycle; channel-to-channel overhead is 2 cycles (EMIT, START).
REQ-025 CHEN changes after the latch SHALL not affect the current frame.
REQ-026 ATMCHSEL SHALL hold its one-hot value from START through EMIT inclusive and be exactly one-hot whenever DONE=1.
REQ-027 FRAME_TRIG while BUSY=1 (including the final EMIT cycle) SHALL be dropped and SHALL invert TRIG_OVERRUN.
REQ-028 ENSAMP_sync low in any state SHALL force IDLE next cycle, with ATMCHSEL, ADC_START, DONE, LASTWORD and RESULT cleared; no partial-frame DONE is emitted. Toggles hold.

Reset
REQ-029 RST_sync high SHALL asynchronously force IDLE and set every output and internal register to 0, including both toggles.
REQ-030 Deassertion SHALL be taken synchronously to SAMPLE_CLK; the first FRAME_TRIG is honoured on the first edge after release.

Configuration
REQ-031 Macro SEQ_TIMEOUT_EN defined: a counter clears on CONV entry and increments each CONV cycle; at TIMEOUT_CYCLES without ADC_DONE the FSM SHALL go EMIT with RESULT=16'hFFFF and invert ADC_TIMEOUT.
REQ-032 SEQ_TIMEOUT_EN defined: ADC_DONE in the same cycle the limit is reached SHALL win; the real result is emitted and there is no toggle.
REQ-033 SEQ_TIMEOUT_EN undefined: CONV SHALL wait indefinitely; ADC_TIMEOUT tied 0; no counter logic.

Verification
REQ-034 CHEN=8'h25, trigger, ADC_DONE 3 cycles after each START with results A,B,C -> DONE x3, ATMCHSEL 01/04/20, LASTWORD only on 20, RESULT A,B,C.
REQ-035 CHEN=8'h80 -> one DONE with ATMCHSEL=8'h80, LASTWORD=1; CHEN=0 trigger -> no ADC_START.
REQ-036 FRAME_TRIG repeated mid-frame and in the final EMIT cycle -> TRIG_OVERRUN toggles twice; frame output unchanged.
REQ-037 ENSAMP_sync dropped in CONV of channel 2 of 4 -> IDLE next cycle, no further DONE; next trigger restarts at the lowest channel.
REQ-038 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ADC_DONE -> DONE with RESULT=16'hFFFF and ADC_TIMEOUT toggled; ADC_DONE on the 4th cycle -> real result, no toggle.
REQ-039 RST_sync pulsed mid-EMIT -> all outputs 0 immediately (asynchronously); BUSY=0.
